traffic_light_fsm: RTL and testbench

- Two-road intersection controller: highway (default green) and farm road (sensor-driven).
- Moore FSM with a dwell timer and a sticky farm-road request latch.
- State register and timer are flop-based; light outputs decode the state register and drive the lamp/LED output stage directly.
- A prescaler upstream supplies a one-cycle tick that paces all timing.

---
 rtl/traffic_pkg.sv | 16 +
 rtl/dwell_timer.sv | 14 +
 rtl/traffic_light_fsm.sv | 71 +++++++
 tb/tb_traffic_light_fsm.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: state codes, lamp encodings and widths shared by the intersection controller.
package traffic_pkg;
  localparam int STATE_W = 3;
  localparam int LIGHT_W = 2;
  typedef enum logic [STATE_W-1:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    FG  = 3'd3,
    FY  = 3'd4,
    AR2 = 3'd5
  } state_t;
  localparam logic [LIGHT_W-1:0] LIGHT_RED    = 2'b00;
  localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = 2'b10;
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: tick-paced saturating counter, cleared whenever the controller changes state.
module dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             tick,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk)
    if (!reset || clr) count <= '0;
    else if (tick && count != '1) count <= count + CNT_W'(1);
endmodule

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: highway/farm-road Moore controller with dwell timer and sticky farm request.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN   = 4,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int FG_MIN      = 2,
  parameter int FG_MAX      = 5,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               car_sense,
  output logic [LIGHT_W-1:0] hwy_light,
  output logic [LIGHT_W-1:0] farm_light,
  output logic [STATE_W-1:0] state,
  output logic               farm_req
);
  localparam logic [CNT_W-1:0] T_GREEN  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] T_FG_MIN = CNT_W'(FG_MIN - 1);
  localparam logic [CNT_W-1:0] T_FG_MAX = CNT_W'(FG_MAX - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] t;
  dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state_d != state_q),
    .tick  (tick),
    .count (t)
  );
  // entering FG serves the request, so the clear beats a same-edge set
  always_ff @(posedge clk)
    if (!reset) begin
      state_q  <= HG;
      farm_req <= 1'b0;
    end else begin
      state_q  <= state_d;
      farm_req <= (state_d == FG && state_q != FG) ? 1'b0 : farm_req | (car_sense && state_q != FG);
    end
  always_comb begin
    state_d    = state_q;
    hwy_light  = LIGHT_RED;
    farm_light = LIGHT_RED;
    case (state_q)
      HG: begin
        hwy_light = LIGHT_GREEN;
        state_d   = (tick && t >= T_GREEN && farm_req) ? HY : HG;
      end
      HY: begin
        hwy_light = LIGHT_YELLOW;
        state_d   = (tick && t == T_YELLOW) ? AR1 : HY;
      end
      AR1: state_d = (tick && t == T_ALLRED) ? FG : AR1;
      FG: begin
        farm_light = LIGHT_GREEN;
        state_d    = (tick && ((t >= T_FG_MIN && !car_sense) || t == T_FG_MAX)) ? FY : FG;
      end
      FY: begin
        farm_light = LIGHT_YELLOW;
        state_d    = (tick && t == T_YELLOW) ? AR2 : FY;
      end
      AR2: state_d = (tick && t == T_ALLRED) ? HG : AR2;
      default: state_d = HG;
    endcase
  end
  assign state = state_q;
endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb_traffic_light_fsm: vector table, directed corner sequences and random traffic against a phase/dwell model.
module tb_traffic_light_fsm;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       car_sense = 1'b0;
  logic [1:0] hwy_light, farm_light;
  logic [2:0] state;
  logic       farm_req;

  traffic_light_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .car_sense  (car_sense),
    .hwy_light  (hwy_light),
    .farm_light (farm_light),
    .state      (state),
    .farm_req   (farm_req)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int gcount = 0;
  int tick_period = 1;

  // model: phase index, ticks spent in the phase, pending request
  int mp = 0;
  int mn = 0;
  bit mr = 1'b0;
  int         dw[6]     = '{4, 2, 1, 2, 2, 1};
  logic [1:0] hw_tab[6] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] fm_tab[6] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};

  typedef struct {
    bit         car;
    logic [2:0] st;
    logic [1:0] hw;
    logic [1:0] fm;
    bit         req;
  } vec_t;
  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit tk, input bit c);
    bit leave, done, nr;
    if (!r) begin
      mp = 0; mn = 0; mr = 1'b0;
    end else begin
      done  = (mn + 1) >= dw[mp];
      leave = tk && (mp == 0 ? (done && mr) : mp == 3 ? ((done && !c) || (mn + 1) >= 5) : done);
      nr = mr | (c && mp != 3);
      if (leave && mp == 2) nr = 1'b0;
      if (leave) begin
        mp = (mp + 1) % 6; mn = 0;
      end else if (tk) mn++;
      mr = nr;
    end
  endtask

  task automatic cmp_model();
    logic [7:0] et;
    et = (mn > 255) ? 8'hff : 8'(mn);
    check("model", {state, hwy_light, farm_light, farm_req, dut.u_timer.count},
          {3'(mp), hw_tab[mp], fm_tab[mp], mr, et});
  endtask

  task automatic step(input bit r, input bit tk, input bit c);
    @(negedge clk);
    reset = r; tick = tk; car_sense = c;
    model(r, tk, c);
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic step_glitch(input bit tk, input bit c);
    @(negedge clk);
    tick = tk; car_sense = c; reset = 1'b0;
    #2 reset = 1'b1;
    model(1'b1, tk, c);
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic go(input bit c);
    step(1'b1, (gcount % tick_period) == 0, c);
    gcount++;
  endtask

  task automatic do_reset();
    repeat (3) step(1'b0, 1'b1, 1'b0);
    gcount = 0;
    tick_period = 1;
  endtask

  task automatic wait_for(input logic [2:0] tgt, input bit c);
    int k = 0;
    while (state != tgt && k < 200) begin
      go(c);
      k++;
    end
    check("reach_state", state, tgt);
  endtask

  task automatic dwell(input bit c, output int n);
    logic [2:0] cur;
    cur = state;
    n = 0;
    do begin
      go(c);
      n++;
    end while (state == cur && n < 1000);
  endtask

  initial begin
    int n;
    tbl[0]  = '{0, 3'd0, 2'b10, 2'b00, 0};
    tbl[1]  = '{1, 3'd0, 2'b10, 2'b00, 1};
    tbl[2]  = '{0, 3'd0, 2'b10, 2'b00, 1};
    tbl[3]  = '{0, 3'd1, 2'b01, 2'b00, 1};
    tbl[4]  = '{0, 3'd1, 2'b01, 2'b00, 1};
    tbl[5]  = '{0, 3'd2, 2'b00, 2'b00, 1};
    tbl[6]  = '{0, 3'd3, 2'b00, 2'b10, 0};
    tbl[7]  = '{0, 3'd3, 2'b00, 2'b10, 0};
    tbl[8]  = '{0, 3'd4, 2'b00, 2'b01, 0};
    tbl[9]  = '{0, 3'd4, 2'b00, 2'b01, 0};
    tbl[10] = '{0, 3'd5, 2'b00, 2'b00, 0};
    tbl[11] = '{0, 3'd0, 2'b10, 2'b00, 0};
    tbl[12] = '{0, 3'd0, 2'b10, 2'b00, 0};

    // idle after reset
    do_reset();
    check("reset_state", {state, hwy_light, farm_light, farm_req}, {3'd0, 2'b10, 2'b00, 1'b0});
    repeat (20) go(1'b0);

    // single request, vector table
    do_reset();
    for (int i = 0; i < 13; i++) begin
      go(tbl[i].car);
      check($sformatf("vec%0d", i), {state, hwy_light, farm_light, farm_req},
            {tbl[i].st, tbl[i].hw, tbl[i].fm, tbl[i].req});
    end

    // continuous traffic
    do_reset();
    wait_for(3'd3, 1'b1);
    dwell(1'b1, n);
    check("fg_max_dwell", n, 5);
    go(1'b1);
    check("req_reset_in_fy", farm_req, 1);
    wait_for(3'd0, 1'b1);
    dwell(1'b1, n);
    check("hg_min_dwell", n, 4);
    check("hg_exit_to_hy", state, 3'd1);

    // tick gating
    do_reset();
    tick_period = 3;
    go(1'b0);
    go(1'b1);
    check("pulse_latched", farm_req, 1);
    wait_for(3'd1, 1'b0);
    dwell(1'b0, n);
    check("hy_dwell_x3", n, 6);
    dwell(1'b0, n);
    check("ar1_dwell_x3", n, 3);
    dwell(1'b0, n);
    check("fg_dwell_x3", n, 6);

    // reset in FG at t=1, then reset pulses between edges
    do_reset();
    go(1'b1);
    wait_for(3'd3, 1'b0);
    go(1'b1);
    check("fg_t1", {state, dut.u_timer.count}, {3'd3, 8'd1});
    step(1'b0, 1'b1, 1'b1);
    check("mid_reset", {state, dut.u_timer.count, farm_req}, {3'd0, 8'd0, 1'b0});
    step_glitch(1'b1, 1'b1);
    step_glitch(1'b1, 1'b0);
    check("glitch_ignored", farm_req, 1);

    // set/clear collision on AR1->FG edge
    do_reset();
    go(1'b1);
    wait_for(3'd2, 1'b0);
    go(1'b1);
    check("collision", {state, farm_req}, {3'd3, 1'b0});

    // timer saturation in long idle HG
    do_reset();
    repeat (258) go(1'b0);
    check("saturated", dut.u_timer.count, 8'hff);
    go(1'b1);
    repeat (4) go(1'b0);

    // illegal state code recovers to HG
    do_reset();
    @(negedge clk);
    tick = 1'b0; car_sense = 1'b0; reset = 1'b1;
    force dut.state_q = traffic_pkg::state_t'(3'd6);
    #1 release dut.state_q;
    @(posedge clk);
    #1;
    check("illegal_to_hg", {state, dut.u_timer.count}, {3'd0, 8'd0});
    cmp_model();

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit r, tk, c;
      r  = $urandom_range(0, 149) != 0;
      tk = (i % 500 < 250) ? 1'b1 : ($urandom_range(0, 2) == 0);
      c  = (i % 400 < 200) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 4) != 0);
      step(r, tk, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule
